// File: rtl/pmod_lab_pkg.sv
// Shared types and helpers for the PMOD logic lab.
// Debounce is enabled with PMOD_LAB_DEBOUNCE_EN.
package pmod_lab_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LOGIC = 2'd0,
    PASS  = 2'd1,
    COUNT = 2'd2,
    SHIFT = 2'd3
  } mode_e;

  function automatic int db_cnt_w(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/pmod_logic_lab_input_cond.sv
// One input channel: 2-flop sync, optional debounce, rise pulse.
// Debounce counter exists only with PMOD_LAB_DEBOUNCE_EN.
module pmod_input_cond
  import pmod_lab_pkg::*;
#(
  parameter int DB_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic level_d;

  if (DB_CYCLES < 2) begin : g_bad_db
    $error("pmod_input_cond: DB_CYCLES must be >= 2");
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level_d <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_d <= level;
    end
  end

`ifdef PMOD_LAB_DEBOUNCE_EN
  localparam int CW = db_cnt_w(DB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Flip only after DB_CYCLES consecutive mismatching samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (s2 == level) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      level <= s2;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign level = s2;
`endif

  assign rise = level & ~level_d;

endmodule

// File: rtl/pmod_logic_lab.sv
// PMOD inputs to LEDs via four button-selected modes.
// Debounce is enabled with PMOD_LAB_DEBOUNCE_EN.
module pmod_logic_lab
  import pmod_lab_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int DB_CYCLES = 12000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_IN-1:0] pmod_in,
  input  logic            mode_btn,
  output logic [N_IN:0]   led
);

  if (N_IN < 4 || N_IN > 8 || DB_CYCLES < 2) begin : g_bad
    $error("pmod_logic_lab: illegal parameters");
  end

  logic [N_IN:0]   raw;
  logic [N_IN:0]   lvl;
  logic [N_IN:0]   rise;
  logic [N_IN-1:0] d;
  logic            d0_rise;
  logic            mode_rise;
  logic            unused_rise;

  mode_e           mode;
  logic [N_IN:0]   cnt;
  logic [N_IN:0]   sh;
  logic [N_IN:0]   led_nxt;

  assign raw = {mode_btn, pmod_in};

  for (genvar i = 0; i <= N_IN; i++) begin : g_ch
    pmod_input_cond #(
      .DB_CYCLES(DB_CYCLES)
    ) u_cond (
      .clk  (clk),
      .rst_n(rst_n),
      .raw  (raw[i]),
      .level(lvl[i]),
      .rise (rise[i])
    );
  end

  assign d           = lvl[N_IN-1:0];
  assign d0_rise     = rise[0];
  assign mode_rise   = rise[N_IN];
  assign unused_rise = ^rise[N_IN-1:1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode <= LOGIC;
      cnt  <= '0;
      sh   <= '0;
      led  <= '0;
    end else begin
      if (mode_rise) begin
        mode <= mode_e'(mode + 2'd1);
      end
      if (d0_rise) begin
        cnt <= cnt + 1'b1;
        sh  <= {sh[N_IN-1:0], d[1]};
      end
      led <= led_nxt;
    end
  end

  always_comb begin
    led_nxt = '0;
    unique case (mode)
      LOGIC: begin
        led_nxt[0]      = d[0] & d[1];
        led_nxt[1]      = d[0] | d[1];
        led_nxt[2]      = !(d[0] & !d[1]);
        led_nxt[3]      = (d[0] & d[1]) | !d[2];
        led_nxt[N_IN:4] = d[N_IN-1:3];
      end
      PASS:  led_nxt = {&d, d};
      COUNT: led_nxt = cnt;
      SHIFT: led_nxt = sh;
      default: led_nxt = '0;
    endcase
  end

endmodule

// File: tb/tb_pmod_logic_lab.sv
// Self-checking bench for pmod_logic_lab (N_IN=4, DB_CYCLES=4).
// Follows PMOD_LAB_DEBOUNCE_EN the same way the RTL does.
module tb_pmod_logic_lab;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int NC = N + 1;
`ifdef PMOD_LAB_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 2;
`else
  localparam int LAT = 2 + 2;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] pmod_in = '0;
  logic         mode_btn = 1'b0;
  logic [N:0]   led;

  int checks = 0;
  int errors = 0;

  pmod_logic_lab #(
    .N_IN     (N),
    .DB_CYCLES(DB)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pmod_in (pmod_in),
    .mode_btn(mode_btn),
    .led     (led)
  );

  always #5 clk = ~clk;

  // Reference model: sampled raw history, debounced values, mode/count/shift.
  logic [N:0]  m_s1 = '0;
  logic [N:0]  m_s2 = '0;
  logic [N:0]  m_d = '0;
  logic [N:0]  m_dp = '0;
  logic [31:0] m_hist [NC];
  int          m_mode = 0;
  logic [N:0]  m_cnt = '0;
  logic [N:0]  m_sh = '0;
  logic [N:0]  m_led = '0;

  initial for (int c = 0; c < NC; c++) m_hist[c] = '0;

  function automatic logic [N:0] led_of(input int mode,
                                        input logic [N:0] dd,
                                        input logic [N:0] cnt,
                                        input logic [N:0] sh);
    logic [N:0]   r;
    logic [N-1:0] v;
    v = dd[N-1:0];
    r = '0;
    case (mode)
      0: begin
        r[0] = v[0] & v[1];
        r[1] = v[0] | v[1];
        r[2] = !(v[0] & !v[1]);
        r[3] = (v[0] & v[1]) | !v[2];
        for (int i = 4; i <= N; i++) r[i] = v[i-1];
      end
      1: r = {&v, v};
      2: r = cnt;
      default: r = sh;
    endcase
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin : mdl
    logic [N:0]  rise;
    logic [N:0]  dn;
    logic [N:0]  raw;
    logic [31:0] h;
    bit          all_diff;
    if (!rst_n) begin
      m_s1   <= '0;
      m_s2   <= '0;
      m_d    <= '0;
      m_dp   <= '0;
      m_mode <= 0;
      m_cnt  <= '0;
      m_sh   <= '0;
      m_led  <= '0;
      for (int c = 0; c < NC; c++) m_hist[c] <= '0;
    end else begin
      raw  = {mode_btn, pmod_in};
      rise = m_d & ~m_dp;
      m_led <= led_of(m_mode, m_d, m_cnt, m_sh);
      if (rise[0]) begin
        m_cnt <= m_cnt + 1'b1;
        m_sh  <= {m_sh[N-1:0], m_d[1]};
      end
      if (rise[N]) m_mode <= (m_mode + 1) % 4;
      m_dp <= m_d;
      for (int c = 0; c < NC; c++) begin
`ifdef PMOD_LAB_DEBOUNCE_EN
        h = {m_hist[c][30:0], m_s2[c]};
        all_diff = 1'b1;
        for (int k = 0; k < DB; k++)
          if (h[k] == m_d[c]) all_diff = 1'b0;
        dn[c] = all_diff ? ~m_d[c] : m_d[c];
        m_hist[c] <= h;
`else
        h = '0;
        all_diff = 1'b0;
        dn[c] = m_s1[c];
`endif
      end
      m_d  <= dn;
      m_s2 <= m_s1;
      m_s1 <= raw;
    end
  end

  always @(negedge clk) begin
    checks++;
    if (led !== m_led) begin
      errors++;
      $display("FAIL model_led t=%0t led=%b expected=%b",
               $time, led, m_led);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_lit(input string name, input logic [N:0] exp);
    checks++;
    if (led !== exp || m_led !== exp) begin
      errors++;
      $display("FAIL %s led=%b model=%b required=%b",
               name, led, m_led, exp);
    end
  endtask

  task automatic press_mode();
    mode_btn = 1'b1;
    cyc(8);
    mode_btn = 1'b0;
    cyc(8);
  endtask

  task automatic toggle_p0();
    pmod_in[0] = 1'b1;
    cyc(8);
    pmod_in[0] = 1'b0;
    cyc(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0] pat;
    pat = 4'b1011;
    cyc(3);
    check_lit("reset_led", 5'b00000);
    rst_n = 1'b1;
    cyc(1);
    check_lit("first_after_reset", 5'b01100);

    pmod_in[1:0] = 2'b11;
    cyc(10);
    check_lit("logic_p0p1", 5'b01111);
    pmod_in[2] = 1'b1;
    cyc(3);
    pmod_in[2] = 1'b0;
    cyc(10);
    check_lit("glitch_rejected", 5'b01111);

    pmod_in = '0;
    cyc(10);
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    press_mode();
    press_mode();
    repeat (5) toggle_p0();
    check_lit("count5", 5'd5);
    repeat (27) toggle_p0();
    check_lit("count_wrap", 5'd0);

    press_mode();
    check_lit("shift_empty", 5'd0);
    for (int i = 3; i >= 0; i--) begin
      pmod_in[1] = pat[i];
      cyc(8);
      toggle_p0();
    end
    check_lit("shift_1011", 5'b01011);
    repeat (3) press_mode();
    check_lit("count_retained", 5'd4);

    repeat (3) press_mode();
    check_lit("pass_mode", 5'b00010);
    pmod_in[0] = 1'b1;
    mode_btn   = 1'b1;
    cyc(LAT - 1);
    check_lit("simul_pass_d0", 5'b00011);
    cyc(1);
    check_lit("simul_count", 5'd5);
    mode_btn   = 1'b0;
    pmod_in[0] = 1'b0;
    cyc(10);

    repeat (4) toggle_p0();
    check_lit("count9", 5'd9);
    pmod_in[0] = 1'b1;
    cyc(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_lit("async_clear", 5'd0);
    pmod_in = '0;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1);
    check_lit("release_logic", 5'b01100);
    press_mode();
    press_mode();
    check_lit("no_spurious_count", 5'd0);

    for (int s = 0; s < 400; s++) begin
      pmod_in  = N'($urandom);
      mode_btn = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 8));
      if ($urandom_range(0, 39) == 0) begin
        @(posedge clk);
        #3 rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
      end
    end
    cyc(5);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
